proc_ctrl_seq: RTL and testbench

Control sequencer that sits directly upstream of the processor datapath (R0/R1 registers and the 8-bit register file). It owns the 5-bit program counter and fetches 8-bit instructions from a synchronous program ROM. It decodes each instruction into one-cycle load/store and register enable strobes. It also generates the internal reset from the external reset.

---
 rtl/proc_ctrl_seq.sv | 146 ++++++++++++++
 tb/tb_proc_ctrl_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_ctrl_seq.sv
// Control sequencer: owns the PC, fetches from a synchronous ROM, and emits one-cycle
// datapath strobes in a FETCH/DECODE/EXEC rhythm. It also builds the datapath's internal reset.
module proc_ctrl_seq #(
  parameter int PC_W            = 5,
  parameter int INSTR_W         = 8,
  parameter int RST_SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn_ext,
  input  logic [INSTR_W-1:0] instr_data,
  input  logic               zero_flag,
  output logic               rstn_inter,
  output logic [PC_W-1:0]    prog_cnt,
  output logic [PC_W-1:0]    instr_addr,
  output logic [PC_W-1:0]    mem_addr,
  output logic               load_en,
  output logic               store_en,
  output logic               R0_ce,
  output logic               R1_ce,
  output logic               R0_en,
  output logic               R1_en,
  output logic               halted,
  output logic [2:0]         state_dbg
);

  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [2:0] OP_LDR0 = 3'b001;
  localparam logic [2:0] OP_LDR1 = 3'b010;
  localparam logic [2:0] OP_STR0 = 3'b011;
  localparam logic [2:0] OP_STR1 = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_JZ   = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  state_t                     state_q;
  logic [RST_SYNC_STAGES-1:0] sync_q;
  logic [PC_W-1:0]            pc_q, pc_d, pc_inc;
  logic [PC_W-1:0]            instr_addr_q, mem_addr_q;
  logic [INSTR_W-1:0]         ir_q;
  logic [2:0]                 ir_op, in_op;
  logic [PC_W-1:0]            ir_operand;
  logic load_q, store_q, r0_ce_q, r1_ce_q, r0_en_q, r1_en_q, halted_q;

  // Reset assertion is immediate; release ripples through the synchronizer chain.
  always_ff @(posedge clk or negedge rstn_ext) begin
    if (!rstn_ext) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[RST_SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign ir_op      = ir_q[INSTR_W-1 -: 3];
  assign ir_operand = ir_q[PC_W-1:0];
  assign in_op      = instr_data[INSTR_W-1 -: 3];
  assign pc_inc     = pc_q + PC_W'(1);

  always_comb begin
    pc_d = pc_inc;
    case (ir_op)
      OP_JMP:  pc_d = ir_operand;
      OP_JZ:   pc_d = zero_flag ? ir_operand : pc_inc;
      OP_HALT: pc_d = pc_q;
      default: pc_d = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge rstn_ext) begin
    if (!rstn_ext) begin
      state_q      <= S_RST;
      pc_q         <= '0;
      instr_addr_q <= '0;
      mem_addr_q   <= '0;
      ir_q         <= '0;
      load_q       <= 1'b0;
      store_q      <= 1'b0;
      r0_ce_q      <= 1'b0;
      r1_ce_q      <= 1'b0;
      r0_en_q      <= 1'b0;
      r1_en_q      <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      // Strobes live for exactly the EXEC cycle, so they clear by default every edge.
      load_q  <= 1'b0;
      store_q <= 1'b0;
      r0_ce_q <= 1'b0;
      r1_ce_q <= 1'b0;
      r0_en_q <= 1'b0;
      r1_en_q <= 1'b0;
      case (state_q)
        S_RST: begin
          if (sync_q[RST_SYNC_STAGES-1]) begin
            state_q      <= S_FETCH;
            instr_addr_q <= pc_q;
          end
        end
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          ir_q       <= instr_data;
          mem_addr_q <= instr_data[PC_W-1:0];
          state_q    <= S_EXEC;
          case (in_op)
            OP_LDR0: begin load_q  <= 1'b1; r0_ce_q <= 1'b1; end
            OP_LDR1: begin load_q  <= 1'b1; r1_ce_q <= 1'b1; end
            OP_STR0: begin store_q <= 1'b1; r0_en_q <= 1'b1; end
            OP_STR1: begin store_q <= 1'b1; r1_en_q <= 1'b1; end
            default: ;
          endcase
        end
        S_EXEC: begin
          pc_q <= pc_d;
          if (ir_op == OP_HALT) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q      <= S_FETCH;
            instr_addr_q <= pc_d;
          end
        end
        S_HALT:  state_q <= S_HALT;
        default: state_q <= S_RST;
      endcase
    end
  end

  assign rstn_inter = sync_q[RST_SYNC_STAGES-1];
  assign prog_cnt   = pc_q;
  assign instr_addr = instr_addr_q;
  assign mem_addr   = mem_addr_q;
  assign load_en    = load_q;
  assign store_en   = store_q;
  assign R0_ce      = r0_ce_q;
  assign R1_ce      = r1_ce_q;
  assign R0_en      = r0_en_q;
  assign R1_en      = r1_en_q;
  assign halted     = halted_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// Bench for proc_ctrl_seq: an instruction-level interpreter predicts every cycle of output,
// and directed literal checks pin key cycles of each program.
module tb_proc_ctrl_seq;

  logic       clk;
  logic       rstn_ext;
  logic [7:0] instr_data;
  logic       zero_flag;
  logic       rstn_inter;
  logic [4:0] prog_cnt, instr_addr, mem_addr;
  logic       load_en, store_en, R0_ce, R1_ce, R0_en, R1_en, halted;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  logic [7:0] rom [32];

  // Interpreter state: current pc, cycle within the 3-cycle instruction, halted flag.
  logic       m_active = 1'b0;
  logic [4:0] m_pc     = '0;
  int         m_cyc    = 0;
  logic       m_halted = 1'b0;

  proc_ctrl_seq dut (
    .clk        (clk),
    .rstn_ext   (rstn_ext),
    .instr_data (instr_data),
    .zero_flag  (zero_flag),
    .rstn_inter (rstn_inter),
    .prog_cnt   (prog_cnt),
    .instr_addr (instr_addr),
    .mem_addr   (mem_addr),
    .load_en    (load_en),
    .store_en   (store_en),
    .R0_ce      (R0_ce),
    .R1_ce      (R1_ce),
    .R0_en      (R0_en),
    .R1_en      (R1_en),
    .halted     (halted),
    .state_dbg  (state_dbg)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous program ROM
  always @(posedge clk) instr_data <= rom[instr_addr];

  function automatic logic [5:0] strobes();
    return {load_en, store_en, R0_ce, R1_ce, R0_en, R1_en};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process: one instruction-level prediction per cycle
  always @(negedge clk) begin
    if (m_active) begin
      logic [2:0] op;
      logic [4:0] opd;
      logic [5:0] exp_str;
      op      = rom[m_pc][7:5];
      opd     = rom[m_pc][4:0];
      exp_str = 6'b000000;
      if (!m_halted && m_cyc == 2) begin
        case (op)
          3'd1:    exp_str = 6'b101000;
          3'd2:    exp_str = 6'b100100;
          3'd3:    exp_str = 6'b010010;
          3'd4:    exp_str = 6'b010001;
          default: exp_str = 6'b000000;
        endcase
      end
      chk("m_prog_cnt", 32'(prog_cnt), 32'(m_pc));
      chk("m_instr_addr", 32'(instr_addr), 32'(m_pc));
      chk("m_strobes", 32'(strobes()), 32'(exp_str));
      chk("m_halted", 32'(halted), 32'(m_halted));
      chk("m_rstn_inter", 32'(rstn_inter), 32'd1);
      if (!m_halted && m_cyc == 2) chk("m_mem_addr", 32'(mem_addr), 32'(opd));
      if (!m_halted) begin
        if (m_cyc == 2) begin
          m_cyc = 0;
          case (op)
            3'd5:    m_pc = opd;
            3'd6:    m_pc = zero_flag ? opd : m_pc + 5'd1;
            3'd7:    m_halted = 1'b1;
            default: m_pc = m_pc + 5'd1;
          endcase
        end else begin
          m_cyc++;
        end
      end
    end
  end

  // driver tasks
  task automatic load_rom_nops();
    for (int i = 0; i < 32; i++) rom[i] = 8'h00;
  endtask

  task automatic do_reset();
    m_active = 1'b0;
    rstn_ext = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_rstn_inter", 32'(rstn_inter), 32'd0);
    chk("rst_prog_cnt", 32'(prog_cnt), 32'd0);
    chk("rst_instr_addr", 32'(instr_addr), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_strobes", 32'(strobes()), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rstn_ext = 1'b1;
    @(posedge clk); #1;
    chk("sync_edge1", 32'(rstn_inter), 32'd0);
    @(posedge clk); #1;
    chk("sync_edge2", 32'(rstn_inter), 32'd1);
    chk("sync_strobes", 32'(strobes()), 32'd0);
    @(posedge clk); #1;
    m_pc     = '0;
    m_cyc    = 0;
    m_halted = 1'b0;
    m_active = 1'b1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rstn_ext  = 1'b0;
    zero_flag = 1'b0;
    load_rom_nops();

    // straight-line program
    rom[0] = 8'h25; rom[1] = 8'h66; rom[2] = 8'h47; rom[3] = 8'h00;
    do_reset();
    wait_cyc(1);
    chk("sl_first_fetch", 32'(instr_addr), 32'd0);
    wait_cyc(2);
    chk("sl_c3_str", 32'(strobes()), 32'b101000);
    chk("sl_c3_addr", 32'(mem_addr), 32'd5);
    wait_cyc(3);
    chk("sl_c6_str", 32'(strobes()), 32'b010010);
    chk("sl_c6_addr", 32'(mem_addr), 32'd6);
    wait_cyc(3);
    chk("sl_c9_str", 32'(strobes()), 32'b100100);
    chk("sl_c9_addr", 32'(mem_addr), 32'd7);
    wait_cyc(3);
    chk("sl_c12_str", 32'(strobes()), 32'd0);
    wait_cyc(1);
    chk("sl_pc_after", 32'(prog_cnt), 32'd4);

    // JZ taken, then JMP back to 0
    load_rom_nops();
    rom[0] = 8'hCA; rom[10] = 8'hA0;
    zero_flag = 1'b1;
    do_reset();
    wait_cyc(4);
    chk("jz_taken_addr", 32'(instr_addr), 32'd10);
    wait_cyc(3);
    chk("jmp_back_addr", 32'(instr_addr), 32'd0);

    // JZ not taken
    zero_flag = 1'b0;
    do_reset();
    wait_cyc(4);
    chk("jz_not_taken_addr", 32'(instr_addr), 32'd1);

    // wrap-around with an all-NOP ROM
    load_rom_nops();
    do_reset();
    wait_cyc(94);
    chk("wrap_pc31", 32'(prog_cnt), 32'd31);
    wait_cyc(3);
    chk("wrap_pc0", 32'(prog_cnt), 32'd0);
    wait_cyc(96);
    chk("wrap_period", 32'(prog_cnt), 32'd0);

    // halt
    load_rom_nops();
    rom[2] = 8'hE0;
    do_reset();
    wait_cyc(10);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc", 32'(prog_cnt), 32'd2);
    wait_cyc(50);
    chk("halt_hold_flag", 32'(halted), 32'd1);
    chk("halt_hold_pc", 32'(prog_cnt), 32'd2);
    chk("halt_hold_str", 32'(strobes()), 32'd0);

    // reset during EXEC of an LDR0
    load_rom_nops();
    rom[0] = 8'h25;
    do_reset();
    wait_cyc(3);
    chk("mid_pre_load", 32'(load_en), 32'd1);
    #2;
    m_active = 1'b0;
    rstn_ext = 1'b0;
    #1;
    chk("mid_load_en", 32'(load_en), 32'd0);
    chk("mid_r0_ce", 32'(R0_ce), 32'd0);
    chk("mid_rstn_inter", 32'(rstn_inter), 32'd0);
    chk("mid_prog_cnt", 32'(prog_cnt), 32'd0);
    do_reset();
    wait_cyc(3);
    chk("mid_restart_str", 32'(strobes()), 32'b101000);
    chk("mid_restart_addr", 32'(mem_addr), 32'd5);
    wait_cyc(2);
    m_active = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
